ks_adder_arbiter: RTL and testbench
===================================

Name: ks_adder_arbiter

Overview:
- Shares one 16-bit koggeStoneAdder instance (operands a, b; 17-bit sum; no carry-in) between NREQ independent requesters.
- Uses a round-robin arbiter with per-requester valid/ready handshakes.
- Registers the adder result into a single-entry output stage that carries the requester ID, with valid/ready backpressure.
- Sits between operand producers and the shared adder datapath; throughput is one addition per cycle.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of rsp_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  bit i: requester i presents an operand pair.
- req_ready  output  NREQ  bit i: requester i's pair is accepted this cycle; at most one bit set.
- req_a  input  NREQ*16  operand a; requester i uses bits [16*i+15:16*i].
- req_b  input  NREQ*16  operand b; same packing as req_a.
- rsp_valid  output  1  output register holds a result.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  IDW  index of the requester that owns rsp_sum.
- rsp_sum  output  17  a+b, zero-extended; bit 16 is the carry-out.
- op_count  output  16  count of completed request handshakes; saturates at 16'hFFFF.

Behaviour:
- Reset (async on rst_n low): rsp_valid=0, rsp_id=0, rsp_sum=0, op_count=0, last_grant=NREQ-1 (so requester 0 has highest priority first), FSM=EMPTY. req_ready is 0 whenever rst_n is low.
- Output stage FSM, two states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- can_accept = (state==EMPTY) | rsp_ready.
- Arbitration is combinational within the cycle:
  - Scan req_valid starting at (last_grant+1) mod NREQ, wrapping around.
  - The first asserted bit is the grant g.
  - req_ready = one-hot(g) when can_accept and any req_valid; all zeros otherwise.
  - req_ready may depend on req_valid. No requester may make req_valid depend on req_ready.
- Handshake on requester g (req_valid[g] & req_ready[g]):
  - The adder is driven with req_a[g], req_b[g].
  - At the next edge: rsp_sum <= adder sum, rsp_id <= g, last_grant <= g, state <= FULL, op_count increments unless already saturated.
- Latency: exactly 1 cycle from request handshake to rsp_valid.
- Output handshake:
  - rsp_valid & rsp_ready with no new grant in the same cycle: state <= EMPTY.
  - Both handshakes in the same cycle: state stays FULL and the register is overwritten with the new result. This gives back-to-back throughput of 1 per cycle.
- Backpressure: state FULL & !rsp_ready means req_ready=0 for all requesters. rsp_sum and rsp_id hold stable while rsp_valid & !rsp_ready.
- last_grant updates only on a request handshake. Idle cycles do not rotate priority.
- Starvation bound: a requester holding req_valid high is granted within NREQ accepted handshakes.
- Width rules:
  - No truncation. rsp_sum[16] is the carry-out.
  - Maximum sum is 16'hFFFF+16'hFFFF = 17'h1FFFE.
  - Operands are unsigned.
- Operand inputs of non-granted requesters are don't-care and do not affect any output.
- Reset mid-operation: a pending result is discarded and the arbiter restarts at requester 0. Requesters must re-present any operands not yet handshaken.

Decomposition:
- Package ks_pkg holds:
  - ADD_W=16 and SUM_W=17.
  - Default NREQ/IDW.
  - The FSM state encoding (EMPTY=1'b0, FULL=1'b1).
- Sub-module ks_rr_arbiter: inputs req, last_grant, enable; outputs one-hot grant and binary grant index. It is purely combinational.
- The top level instantiates koggeStoneAdder unchanged as its only adder.

Test Plan:
- Single request: after reset, req_valid=4'b0001, a=15, b=8, rsp_ready=1 -> req_ready=4'b0001 in the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_sum=23, op_count=1.
- Round robin: all four valid continuously with operands (200,490), (1981,5196), (5158,25000), (32768,32767), rsp_ready=1 -> grants in order 0,1,2,3,0,...; sums 690, 7177, 30158, 65535 on consecutive cycles.
- Carry-out: requester 2 sends a=65535, b=65535 -> rsp_sum=17'h1FFFE (131070), rsp_id=2.
- Backpressure: rsp_ready=0 with a result held and requesters 1 and 3 valid -> req_ready=0 and rsp_sum/rsp_id stable for 5 cycles. On raising rsp_ready, requester 1 is accepted in the same cycle as the drain, and requester 3 on the next cycle.
- Idle gaps: requester 3 is served, the bus idles for 3 cycles, then requesters 0 and 3 both assert -> 0 is granted first, because the pointer did not rotate during idle.
- Async reset mid-operation: rst_n pulsed low while FULL with 2 requesters pending -> rsp_valid, op_count, rsp_sum and req_ready go to 0 immediately, without waiting for a clock edge. After release, requester 0 has highest priority.

Source files
------------

// File: rtl/ks_pkg.sv
// Shared constants and the output-stage state encoding for ks_adder_arbiter.
package ks_pkg;
  localparam int ADD_W    = 16;
  localparam int SUM_W    = 17;
  localparam int DEF_NREQ = 4;
  localparam int DEF_IDW  = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;
endpackage

// File: rtl/koggeStoneAdder.sv
// 16-bit Kogge-Stone parallel-prefix adder, no carry-in, 17-bit sum.
module koggeStoneAdder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [16:0] sum
);
  localparam int W = 16;
  localparam int L = 4;  // log2(W) prefix levels

  logic [W-1:0] gen [0:L];
  logic [W-1:0] prop [0:L];

  // Prefix tree: level l combines each bit with the one 2**(l-1) below it.
  always_comb begin
    for (int l = 0; l <= L; l++) begin
      gen[l]  = '0;
      prop[l] = '0;
    end
    gen[0]  = a & b;
    prop[0] = a ^ b;
    for (int l = 1; l <= L; l++) begin
      for (int i = 0; i < W; i++) begin
        if (i >= (1 << (l - 1))) begin
          gen[l][i]  = gen[l-1][i] | (prop[l-1][i] & gen[l-1][i-(1<<(l-1))]);
          prop[l][i] = prop[l-1][i] & prop[l-1][i-(1<<(l-1))];
        end else begin
          gen[l][i]  = gen[l-1][i];
          prop[l][i] = prop[l-1][i];
        end
      end
    end
  end

  // Sum bit i is the half-sum xor the group carry out of bits [i-1:0].
  always_comb begin
    sum    = '0;
    sum[0] = prop[0][0];
    for (int i = 1; i < W; i++) sum[i] = prop[0][i] ^ gen[L][i-1];
    sum[W] = gen[L][W-1];
  end
endmodule

// File: rtl/ks_rr_arbiter.sv
// Combinational round-robin pick: first set bit of req after last_grant, wrapping.
module ks_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  input  logic            enable,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);
  logic found;

  // Visit positions last_grant+1 .. last_grant+NREQ (mod NREQ); first hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (enable && !found && req[i] && (i == (int'(last_grant) + k) % NREQ)) begin
          found     = 1'b1;
          grant[i]  = 1'b1;
          grant_idx = IDW'(i);
        end
      end
    end
  end
endmodule

// File: rtl/ks_adder_arbiter.sv
// One shared Kogge-Stone adder fed by NREQ round-robin requesters, with a
// single registered result stage carrying the owner's ID.
module ks_adder_arbiter
  import ks_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = DEF_IDW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*ADD_W-1:0] req_a,
  input  logic [NREQ*ADD_W-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [SUM_W-1:0]      rsp_sum,
  output logic [15:0]           op_count
);
  state_t           state, state_next;
  logic [IDW-1:0]   last_grant, grant_idx;
  logic [NREQ-1:0]  grant;
  logic             can_accept, fire;
  logic [ADD_W-1:0] op_a, op_b;
  logic [SUM_W-1:0] sum;

  // A slot opens when the register is empty or drains this same cycle.
  assign can_accept = (state == EMPTY) | rsp_ready;

  // rst_n gates enable so nothing is offered while reset is held.
  ks_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .enable     (can_accept & rst_n),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign req_ready = grant;
  assign fire      = |grant;  // grant is only ever given to a valid requester
  assign rsp_valid = (state == FULL);

  // One-hot operand mux; idle requesters' operands never reach the adder.
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        op_a = req_a[i*ADD_W +: ADD_W];
        op_b = req_b[i*ADD_W +: ADD_W];
      end
    end
  end

  koggeStoneAdder u_add (
    .a   (op_a),
    .b   (op_b),
    .sum (sum)
  );

  // Next state: a new result always fills; otherwise a drain empties.
  always_comb begin
    state_next = state;
    if (fire)           state_next = FULL;
    else if (rsp_ready) state_next = EMPTY;
  end

  // Output-stage state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  // Result capture, priority pointer and saturating handshake counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_sum    <= '0;
      rsp_id     <= '0;
      last_grant <= IDW'(NREQ - 1);
      op_count   <= '0;
    end else if (fire) begin
      rsp_sum    <= sum;
      rsp_id     <= grant_idx;
      last_grant <= grant_idx;
      if (op_count != 16'hFFFF) op_count <= op_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_ks_adder_arbiter.sv
// Scoreboard bench for ks_adder_arbiter: expected {id,sum} queued at each
// request handshake, popped at each response handshake, plus directed checks.
module tb_ks_adder_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef struct {
    logic [IDW-1:0] id;
    logic [16:0]    sum;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*16-1:0] req_a, req_b;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [16:0]       rsp_sum;
  logic [15:0]       op_count;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_ops = 0;

  always #5 clk = ~clk;

  ks_adder_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .op_count  (op_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    sb.delete();
    n_ops = 0;
    step();
    rst_n = 1'b1;
  endtask

  // Protocol checks and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      check("onehot", 32'($countones(req_ready) <= 1), 1);
      check("ready_sub_valid", 32'((req_ready & ~req_valid) == '0), 1);
      check("op_count", 32'(op_count), 32'(n_ops));
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) check("sb_underflow", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_id", 32'(rsp_id), 32'(e.id));
          check("sb_sum", 32'(rsp_sum), 32'(e.sum));
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_t e;
          e.id  = IDW'(i);
          e.sum = {1'b0, req_a[i*16 +: 16]} + {1'b0, req_b[i*16 +: 16]};
          sb.push_back(e);
          if (n_ops < 65535) n_ops++;
        end
      end
    end
  end

  int rr_sum [4] = '{690, 7177, 30158, 65535};

  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    // Reset state, with requests present that must not be offered.
    req_valid = 4'b1111;
    @(negedge clk);
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_id", 32'(rsp_id), 0);
    check("rst_sum", 32'(rsp_sum), 0);
    check("rst_count", 32'(op_count), 0);
    check("rst_ready", 32'(req_ready), 0);
    req_valid = '0;
    step();
    rst_n = 1'b1;

    // Single request, one-cycle latency.
    set_op(0, 15, 8);
    req_valid = 4'b0001;
    @(negedge clk);
    check("t1_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    @(negedge clk);
    check("t1_valid", 32'(rsp_valid), 1);
    check("t1_id", 32'(rsp_id), 0);
    check("t1_sum", 32'(rsp_sum), 23);
    check("t1_count", 32'(op_count), 1);

    // Round robin with all requesters continuously valid.
    do_reset();
    set_op(0, 200, 490);
    set_op(1, 1981, 5196);
    set_op(2, 5158, 25000);
    set_op(3, 32768, 32767);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
      if (k > 0) check("rr_sum", 32'(rsp_sum), 32'(rr_sum[(k-1) % 4]));
      step();
    end
    req_valid = '0;
    @(negedge clk);
    check("rr_sum_last", 32'(rsp_sum), 32'(rr_sum[3]));

    // Carry-out at maximum operands.
    step();
    set_op(2, 16'hFFFF, 16'hFFFF);
    req_valid = 4'b0100;
    @(negedge clk);
    check("co_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    @(negedge clk);
    check("co_sum", 32'(rsp_sum), 32'h1FFFE);
    check("co_id", 32'(rsp_id), 2);

    // Backpressure: hold result from requester 0 while 1 and 3 wait.
    step();
    rsp_ready = 1'b0;
    set_op(0, 100, 200);
    req_valid = 4'b0001;
    @(negedge clk);
    check("bp_fill", 32'(req_ready), 32'h1);
    step();
    set_op(1, 1000, 2000);
    set_op(3, 7, 9);
    req_valid = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_ready", 32'(req_ready), 0);
      check("bp_valid", 32'(rsp_valid), 1);
      check("bp_sum", 32'(rsp_sum), 300);
      check("bp_id", 32'(rsp_id), 0);
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_drain_grant", 32'(req_ready), 32'h2);
    step();
    req_valid = 4'b1000;
    @(negedge clk);
    check("bp_next_grant", 32'(req_ready), 32'h8);
    check("bp_sum1", 32'(rsp_sum), 3000);
    check("bp_id1", 32'(rsp_id), 1);
    step();
    req_valid = '0;
    @(negedge clk);
    check("bp_sum3", 32'(rsp_sum), 16);
    check("bp_id3", 32'(rsp_id), 3);

    // Idle cycles must not rotate priority.
    step();
    set_op(3, 1, 2);
    req_valid = 4'b1000;
    @(negedge clk);
    check("idle_g3", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_ready", 32'(req_ready), 0);
      step();
    end
    check("idle_empty", 32'(rsp_valid), 0);
    set_op(0, 5, 6);
    req_valid = 4'b1001;
    @(negedge clk);
    check("idle_g0", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b1000;
    @(negedge clk);
    check("idle_g3b", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;

    // Async reset while FULL with requesters pending.
    @(negedge clk);
    step();
    rsp_ready = 1'b0;
    set_op(0, 40, 2);
    req_valid = 4'b0001;
    @(negedge clk);
    check("ar_fill", 32'(req_ready), 32'h1);
    step();
    req_valid = 4'b0110;
    @(negedge clk);
    check("ar_held", 32'(req_ready), 0);
    check("ar_full", 32'(rsp_valid), 1);
    #2;
    rst_n = 1'b0;
    sb.delete();
    n_ops = 0;
    #1;
    check("ar_valid", 32'(rsp_valid), 0);
    check("ar_count", 32'(op_count), 0);
    check("ar_sum", 32'(rsp_sum), 0);
    check("ar_ready", 32'(req_ready), 0);
    step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b0111;
    @(negedge clk);
    check("ar_restart", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    @(negedge clk);
    check("ar_sum0", 32'(rsp_sum), 42);
    check("ar_id0", 32'(rsp_id), 0);
    step();
    step();
    check("sb_empty", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
